i2s_rx_param: RTL and testbench

Synthesizable I2S receiver with parametrised sample width and slot length. It oversamples the serial audio bus (sck/ws/sdo) on the system clock and deserialises stereo frames into parallel left/right words. Frames are delivered through a valid/ready handshake. Supports standard I2S (1-bit delay) and left-justified framing, reports short slots, and reports dropped frames. It sits on the audio input path, in front of the sample-processing datapath.

---
 rtl/i2s_rx_param.sv | 186 ++++++++++++++++++
 tb/tb_i2s_rx_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_param.sv
// I2S / left-justified receiver: oversampled sck/ws/sdo deserialised
// into stereo frames delivered over a valid/ready handshake.
module i2s_rx_param #(
  parameter int DATA_WIDTH    = 24,
  parameter int MAX_SLOT_BITS = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_in,
  input  logic                       mode_in,
  input  logic                       sck_in,
  input  logic                       ws_in,
  input  logic                       sdo_in,
  output logic [1:0][DATA_WIDTH-1:0] audio_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       frame_ok_out,
  output logic                       overrun_out
);

  localparam int CW = $clog2(MAX_SLOT_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_LEFT  = 2'd2;
  localparam logic [1:0] S_RIGHT = 2'd3;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sdo_sync;
  logic                   r_sck_d;
  logic                   r_evt;
  logic                   r_ws_s;
  logic                   r_sdo_s;
  logic                   r_ws_prev;
  logic                   r_ch_prev;
  logic                   r_mode;
  logic [1:0]             r_state;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [CW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]  r_left;
  logic                   r_left_ok;

  logic [1:0][DATA_WIDTH-1:0] r_audio;
  logic                       r_valid;
  logic                       r_ok;
  logic                       r_ovr;

  logic                  w_sck;
  logic                  w_ch;
  logic                  w_bound;
  logic                  w_slot_ok;
  logic                  w_commit;
  logic                  w_sat;
  logic [DATA_WIDTH-1:0] w_shift_ins;
  logic [DATA_WIDTH-1:0] w_new_slot;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  // I2S delays the channel by one bit; left-justified uses ws directly
  assign w_ch       = r_mode ? r_ws_s : r_ws_prev;
  assign w_bound    = r_evt && (w_ch != r_ch_prev);
  assign w_slot_ok  = (r_cnt >= CW'(DATA_WIDTH));
  assign w_sat      = (r_cnt == CW'(MAX_SLOT_BITS));
  assign w_new_slot = {r_sdo_s, {(DATA_WIDTH-1){1'b0}}};
  assign w_commit   = enable_in && (r_state == S_RIGHT)
                      && w_bound && !w_ch;

  // Bits land left-aligned so a short slot is zero-padded for free
  always_comb begin
    w_shift_ins = r_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r_cnt == CW'(DATA_WIDTH - 1 - i))
        w_shift_ins[i] = r_sdo_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sdo_sync <= '0;
      r_sck_d    <= 1'b0;
      r_evt      <= 1'b0;
      r_ws_s     <= 1'b0;
      r_sdo_s    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_in};
      r_sdo_sync <= {r_sdo_sync[SYNC_STAGES-2:0], sdo_in};
      r_sck_d    <= w_sck;
      r_evt      <= w_sck && !r_sck_d;
      r_ws_s     <= r_ws_sync[SYNC_STAGES-1];
      r_sdo_s    <= r_sdo_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ws_prev <= 1'b0;
      r_ch_prev <= 1'b0;
      r_mode    <= 1'b0;
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_left    <= '0;
      r_left_ok <= 1'b0;
    end else begin
      // Channel history tracks the bus even when idle
      if (r_evt) begin
        r_ws_prev <= r_ws_s;
        r_ch_prev <= w_ch;
      end
      if (!enable_in) begin
        r_state <= S_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_mode  <= mode_in;
            r_state <= S_WAIT;
            r_shift <= '0;
            r_cnt   <= '0;
          end
          S_WAIT: begin
            if (w_bound && !w_ch) begin
              r_state <= S_LEFT;
              r_shift <= w_new_slot;
              r_cnt   <= CW'(1);
            end
          end
          S_LEFT: begin
            if (w_bound && w_ch) begin
              r_left    <= r_shift;
              r_left_ok <= w_slot_ok;
              r_state   <= S_RIGHT;
              r_shift   <= w_new_slot;
              r_cnt     <= CW'(1);
            end else if (r_evt) begin
              r_shift <= w_shift_ins;
              if (!w_sat) r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RIGHT: begin
            if (w_bound && !w_ch) begin
              r_state <= S_LEFT;
              r_shift <= w_new_slot;
              r_cnt   <= CW'(1);
            end else if (r_evt) begin
              r_shift <= w_shift_ins;
              if (!w_sat) r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_audio <= '0;
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_commit) begin
        r_audio[0] <= r_left;
        r_audio[1] <= r_shift;
        r_ok       <= r_left_ok && w_slot_ok;
        r_valid    <= 1'b1;
        r_ovr      <= r_valid && !ready_in;
      end else if (r_valid && ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign audio_out    = r_audio;
  assign valid_out    = r_valid;
  assign frame_ok_out = r_ok;
  assign overrun_out  = r_ovr;

endmodule

// File: tb/tb_i2s_rx_param.sv
// Directed bench for i2s_rx_param: vector table plus handshake,
// latency, disable and reset sequences.
module tb_i2s_rx_param;

  logic             clk;
  logic             rst_n;
  logic             enable_in;
  logic             mode_in;
  logic             sck_in;
  logic             ws_in;
  logic             sdo_in;
  logic [1:0][23:0] audio_out;
  logic             valid_out;
  logic             ready_in;
  logic             frame_ok_out;
  logic             overrun_out;

  i2s_rx_param #(
    .DATA_WIDTH(24),
    .MAX_SLOT_BITS(32),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_in(enable_in),
    .mode_in(mode_in),
    .sck_in(sck_in),
    .ws_in(ws_in),
    .sdo_in(sdo_in),
    .audio_out(audio_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .frame_ok_out(frame_ok_out),
    .overrun_out(overrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] a;
    logic        ok;
  } rec_t;

  rec_t q[$];
  int   n_ovr = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (valid_out && ready_in)
      q.push_back('{a: audio_out, ok: frame_ok_out});
    if (overrun_out) n_ovr++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic w, input logic d);
    ws_in  = w;
    sdo_in = d;
    repeat (4) @(negedge clk);
    sck_in = 1'b1;
    repeat (4) @(negedge clk);
    sck_in = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] l,
                           input logic [31:0] r,
                           input int n, input bit lj,
                           input int from, input int to);
    logic w;
    logic d;
    for (int k = from; k < to; k++) begin
      if (k < n) begin
        w = lj ? 1'b0 : (k == n - 1);
        d = l[n-1-k];
      end else begin
        w = lj ? 1'b1 : (k != 2*n - 1);
        d = r[2*n-1-k];
      end
      send_bit(w, d);
    end
  endtask

  task automatic send_frame(input logic [31:0] l,
                            input logic [31:0] r,
                            input int n, input bit lj);
    send_bits(l, r, n, lj, 0, 2*n);
  endtask

  task automatic do_reset(input bit mode);
    rst_n     = 1'b0;
    enable_in = 1'b0;
    mode_in   = mode;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    enable_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit          fmt;
    bit          mode;
    int          n;
    logic [31:0] l;
    logic [31:0] r;
    logic [47:0] ea;
    bit          eok;
  } vec_t;

  vec_t vt[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    int obase;
    int lat;

    vt[0] = '{0, 0, 24, 32'hA5A5A5, 32'h5A5A5A,
              {24'h5A5A5A, 24'hA5A5A5}, 1};
    vt[1] = '{1, 1, 24, 32'hA5A5A5, 32'h5A5A5A,
              {24'h5A5A5A, 24'hA5A5A5}, 1};
    vt[2] = '{1, 0, 24, 32'hA5A5A5, 32'h5A5A5A,
              {24'hB4B4B4, 24'h4B4B4A}, 1};
    vt[3] = '{0, 0, 32, 32'h12345678, 32'h9ABCDEF0,
              {24'h9ABCDE, 24'h123456}, 1};
    vt[4] = '{0, 0, 16, 32'hBEEF, 32'hCAFE,
              {24'hCAFE00, 24'hBEEF00}, 0};
    vt[5] = '{1, 1, 16, 32'h1234, 32'h00FF,
              {24'h00FF00, 24'h123400}, 0};

    rst_n     = 1'b0;
    enable_in = 1'b0;
    mode_in   = 1'b0;
    sck_in    = 1'b0;
    ws_in     = 1'b0;
    sdo_in    = 1'b0;
    ready_in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_audio", 64'(audio_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ok",    64'(frame_ok_out), 64'd0);
    chk("rst_ovr",   64'(overrun_out), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset(vt[i].mode);
      base = q.size();
      send_frame(32'h0, 32'h0, vt[i].n, vt[i].fmt);
      send_frame(vt[i].l, vt[i].r, vt[i].n, vt[i].fmt);
      send_frame(32'h0, 32'h0, vt[i].n, vt[i].fmt);
      repeat (12) @(negedge clk);
      chk($sformatf("v%0d_count", i), 64'(q.size() - base), 64'd1);
      if (q.size() > base) begin
        chk($sformatf("v%0d_audio", i), 64'(q[base].a), 64'(vt[i].ea));
        chk($sformatf("v%0d_ok", i), 64'(q[base].ok), 64'(vt[i].eok));
      end
    end

    // first frame after enable is dropped; commit latency
    do_reset(1'b0);
    base = q.size();
    send_frame(32'h0F0F0F, 32'hF0F0F0, 24, 0);
    send_frame(32'h123456, 32'h654321, 24, 0);
    ws_in  = 1'b0;
    sdo_in = 1'b0;
    repeat (4) @(negedge clk);
    sck_in = 1'b1;
    lat = 99;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (valid_out && lat == 99) lat = c;
    end
    sck_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("latency", 64'(lat), 64'd4);
    chk("first_count", 64'(q.size() - base), 64'd1);
    if (q.size() > base)
      chk("first_audio", 64'(q[base].a), {16'h0, 24'h654321, 24'h123456});

    // overrun with ready low, then release
    ready_in = 1'b0;
    do_reset(1'b0);
    base  = q.size();
    obase = n_ovr;
    send_frame(32'h0, 32'h0, 24, 0);
    send_frame(32'h111111, 32'h222222, 24, 0);
    send_frame(32'h333333, 32'h444444, 24, 0);
    send_frame(32'h0, 32'h0, 24, 0);
    repeat (12) @(negedge clk);
    chk("ovr_pulses", 64'(n_ovr - obase), 64'd1);
    chk("ovr_valid", 64'(valid_out), 64'd1);
    chk("ovr_audio", 64'(audio_out), {16'h0, 24'h444444, 24'h333333});
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_drop", 64'(valid_out), 64'd0);
    chk("ovr_count", 64'(q.size() - base), 64'd1);

    // disable then reset mid left slot
    for (int m = 0; m < 2; m++) begin
      do_reset(1'b0);
      base = q.size();
      send_frame(32'h0, 32'h0, 24, 0);
      send_frame(32'hABCDEF, 32'hFEDCBA, 24, 0);
      send_bits(32'h111111, 32'h222222, 24, 0, 0, 10);
      if (m == 0) begin
        enable_in = 1'b0;
        repeat (3) @(negedge clk);
        enable_in = 1'b1;
      end else begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_valid", 64'(valid_out), 64'd0);
        chk("rst_mid_audio", 64'(audio_out), 64'd0);
        rst_n = 1'b1;
      end
      send_bits(32'h111111, 32'h222222, 24, 0, 10, 48);
      send_frame(32'h0C0C0C, 32'hC0C0C0, 24, 0);
      send_frame(32'h0, 32'h0, 24, 0);
      repeat (12) @(negedge clk);
      chk($sformatf("abort%0d_count", m), 64'(q.size() - base), 64'd2);
      if (q.size() > base + 1) begin
        chk($sformatf("abort%0d_f1", m), 64'(q[base].a),
            {16'h0, 24'hFEDCBA, 24'hABCDEF});
        chk($sformatf("abort%0d_f3", m), 64'(q[base+1].a),
            {16'h0, 24'hC0C0C0, 24'h0C0C0C});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
